// File: rtl/boot_seq_pkg.sv
// Shared types and helpers for the board clock/reset/fetch sequencer.
package boot_seq_pkg;
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    ARMED   = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_ARMED   = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  // Counter width for a 0..v-1 count, never narrower than one bit.
  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and
// a one-cycle pulse on the debounced falling (press) edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic deb_o,
  output logic fall_o
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip   = (sync[1] != deb_o) && (cnt == CNT_MAX);
  assign fall_o = flip && !sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      deb_o <= 1'b1;
    end else begin
      sync <= {sync[0], btn_n_i};
      if (sync[1] == deb_o) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        deb_o <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/board_boot_seq.sv
// Board clock divider plus core reset / fetch-enable sequencer; all core-side
// outputs move on the board edge that produces the core clock falling edge.
module board_boot_seq
  import boot_seq_pkg::*;
#(
  parameter int DIV_HALF    = 2,
  parameter int RST_HOLD    = 16,
  parameter int FETCH_DELAY = 8,
  parameter int DEB_CYCLES  = 65536,
  parameter int LONG_TICKS  = 4096,
  parameter int AUTO_FETCH  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_fetch_n,
  output logic       core_clk_o,
  output logic       core_rst_n_o,
  output logic       fetch_enable_o,
  output logic [1:0] state_o
);
  localparam int DW = cw(DIV_HALF);
  localparam int TW = cw(max3(RST_HOLD, FETCH_DELAY, LONG_TICKS));
  localparam logic [DW-1:0] DIV_MAX   = DW'(DIV_HALF - 1);
  localparam logic [TW-1:0] HOLD_MAX  = TW'(RST_HOLD - 1);
  localparam logic [TW-1:0] FETCH_MAX = TW'(FETCH_DELAY - 1);
  localparam logic [TW-1:0] LONG_MAX  = TW'(LONG_TICKS - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          deb, fall, edge_lat, press_edge;
  state_e        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n_i(btn_fetch_n),
    .deb_o  (deb),
    .fall_o (fall)
  );

  assign tick = (div_cnt == DIV_MAX) && core_clk_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      core_clk_o <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt    <= '0;
      core_clk_o <= ~core_clk_o;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Every tick consumes the latch, so an edge seen before ARMED never survives.
  assign press_edge = edge_lat | fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    edge_lat <= 1'b0;
    else if (tick) edge_lat <= 1'b0;
    else if (fall) edge_lat <= 1'b1;
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt + 1'b1;
    case (state)
      HOLD:
        if (tcnt == HOLD_MAX) begin
          state_nx = RELEASE;
          tcnt_nx  = '0;
        end
      RELEASE:
        if (tcnt == FETCH_MAX) begin
          state_nx = ARMED;
          tcnt_nx  = '0;
        end
      ARMED: begin
        tcnt_nx = '0;
        if (AUTO_FETCH != 0 || press_edge) state_nx = RUN;
      end
      RUN:
        if (deb) begin
          tcnt_nx = '0;
        end else if (tcnt == LONG_MAX) begin
          state_nx = HOLD;
          tcnt_nx  = '0;
        end
      default: begin
        state_nx = HOLD;
        tcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= HOLD;
      tcnt           <= '0;
      core_rst_n_o   <= 1'b0;
      fetch_enable_o <= 1'b0;
    end else if (tick) begin
      state          <= state_nx;
      tcnt           <= tcnt_nx;
      core_rst_n_o   <= (state_nx != HOLD);
      fetch_enable_o <= (state_nx == RUN);
    end
  end

  assign state_o = state;
endmodule

// File: tb/tb_board_boot_seq.sv
// Bench for board_boot_seq: table phases, hand sequences and random button
// activity, all compared each cycle against a time-based reference model.
module tb_board_boot_seq;
  localparam int DH = 2, RH = 4, FD = 3, DEB = 8, LT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b1;
  logic       cclk, crst, fen;
  logic [1:0] st;
  logic       a_cclk, a_crst, a_fen;
  logic [1:0] a_st;

  board_boot_seq #(.DIV_HALF(DH), .RST_HOLD(RH), .FETCH_DELAY(FD),
                   .DEB_CYCLES(DEB), .LONG_TICKS(LT), .AUTO_FETCH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_fetch_n(btn), .core_clk_o(cclk),
    .core_rst_n_o(crst), .fetch_enable_o(fen), .state_o(st)
  );

  board_boot_seq #(.DIV_HALF(1), .RST_HOLD(RH), .FETCH_DELAY(FD),
                   .DEB_CYCLES(DEB), .LONG_TICKS(LT), .AUTO_FETCH(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .btn_fetch_n(1'b1), .core_clk_o(a_cclk),
    .core_rst_n_o(a_crst), .fetch_enable_o(a_fen), .state_o(a_st)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  // Reference model: n = board edges since reset release, state by name number.
  int n, m_state, m_ticks;
  bit m_deb, m_edge;
  bit bq[$];
  bit sh[$];

  typedef struct {
    bit         btn;
    int         clks;
    logic [1:0] exp_st;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_state = 0; m_ticks = 0; m_deb = 1'b1; m_edge = 1'b0;
    bq = '{1'b1, 1'b1};
    sh.delete();
  endtask

  task automatic model_edge();
    bit s, old_deb, fall_now, diff, pe;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n++;
    bq.push_back(btn);
    s = bq.pop_front();
    sh.push_back(s);
    if (sh.size() > DEB) void'(sh.pop_front());
    old_deb = m_deb;
    fall_now = 1'b0;
    if (sh.size() == DEB) begin
      diff = 1'b1;
      foreach (sh[i]) if (sh[i] == m_deb) diff = 1'b0;
      if (diff) begin
        m_deb = ~m_deb;
        fall_now = (m_deb == 1'b0);
      end
    end
    if (n % (2 * DH) == 0) begin
      pe = m_edge | fall_now;
      m_edge = 1'b0;
      case (m_state)
        0: begin m_ticks++; if (m_ticks == RH) begin m_state = 1; m_ticks = 0; end end
        1: begin m_ticks++; if (m_ticks == FD) begin m_state = 2; m_ticks = 0; end end
        2: if (pe) begin m_state = 3; m_ticks = 0; end
        default: begin
          m_ticks = old_deb ? 0 : m_ticks + 1;
          if (m_ticks == LT) begin m_state = 0; m_ticks = 0; end
        end
      endcase
    end else if (fall_now) begin
      m_edge = 1'b1;
    end
  endtask

  function automatic logic [4:0] exp_main();
    logic [1:0] s2;
    s2 = m_state[1:0];
    return {s2, m_state != 0, m_state == 3, ((n / DH) % 2) != 0};
  endfunction

  // Auto-fetch instance: tick k lands on edge 2k, so its state follows n directly.
  function automatic logic [4:0] exp_auto();
    int t;
    logic [1:0] s2;
    t = n / 2;
    s2 = (t < RH) ? 2'd0 : (t < RH + FD) ? 2'd1 : (t < RH + FD + 1) ? 2'd2 : 2'd3;
    return {s2, t >= RH, t >= RH + FD + 1, (n % 2) != 0};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("main_outputs", {st, crst, fen, cclk}, exp_main());
    chk("auto_outputs", {a_st, a_crst, a_fen, a_cclk}, exp_auto());
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic wait_state(input string nm, input logic [1:0] tgt, input int budget);
    for (int i = 0; i < budget && st !== tgt; i++) step();
    chk(nm, st, tgt);
  endtask

  initial begin
    tbl[0] = '{btn: 1'b0, clks: 5,  exp_st: 2'd2};
    tbl[1] = '{btn: 1'b1, clks: 20, exp_st: 2'd2};
    tbl[2] = '{btn: 1'b0, clks: 20, exp_st: 2'd3};
    tbl[3] = '{btn: 1'b1, clks: 30, exp_st: 2'd3};
    tbl[4] = '{btn: 1'b0, clks: 30, exp_st: 2'd3};
    tbl[5] = '{btn: 1'b1, clks: 30, exp_st: 2'd3};

    model_reset();
    #1;
    chk("reset_main", {st, crst, fen, cclk}, 5'd0);
    chk("reset_auto", {a_st, a_crst, a_fen, a_cclk}, 5'd0);
    run(3);
    rst_n = 1'b1;

    // Power-up sequence with the button idle.
    for (int i = 0; i < 200; i++) begin
      step();
      if (n == 15) chk("core_rst_before_tick4", crst, 1'b0);
      if (n == 16) chk("core_rst_at_tick4", crst, 1'b1);
      if (n == 27) chk("release_before_tick7", st, 2'd1);
      if (n == 28) chk("armed_at_tick7", st, 2'd2);
      if (n == 14) chk("auto_armed_tick7", a_st, 2'd2);
      if (n == 16) chk("auto_run_tick8", {a_st, a_fen}, {2'd3, 1'b1});
    end
    chk("armed_idle_200", {st, fen}, {2'd2, 1'b0});

    for (int i = 0; i < 6; i++) begin
      btn = tbl[i].btn;
      run(tbl[i].clks);
      chk($sformatf("table_%0d", i), st, tbl[i].exp_st);
    end

    // Long press in RUN re-sequences; held button must not re-arm RUN.
    btn = 1'b0;
    wait_state("long_press_hold", 2'd0, 200);
    chk("long_press_outputs", {crst, fen}, 2'b00);
    wait_state("resequence_armed", 2'd2, 200);
    run(100);
    chk("armed_held_level", st, 2'd2);
    btn = 1'b1;
    run(30);
    btn = 1'b0;
    run(20);
    chk("rerun_after_press", st, 2'd3);

    // Asynchronous reset mid-RUN while core_clk_o is high.
    btn = 1'b1;
    for (int i = 0; i < 8 && cclk !== 1'b1; i++) step();
    chk("cclk_high_before_rst", {st, cclk}, {2'd3, 1'b1});
    rst_n = 1'b0;
    btn = 1'b0;
    #1;
    chk("async_rst_main", {st, crst, fen, cclk}, 5'd0);
    chk("async_rst_auto", {a_st, a_crst, a_fen, a_cclk}, 5'd0);
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(200);
    chk("held_from_reset_armed", st, 2'd2);
    btn = 1'b1;
    run(30);
    btn = 1'b0;
    run(20);
    chk("press_after_release", st, 2'd3);

    for (int i = 0; i < 150; i++) begin
      btn = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 60)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/board_boot_seq.md
# board_boot_seq

FPGA board-level clock/reset/fetch sequencer for the PULPino SoC on the icbv1 board. It replaces the free-running divider and the raw fetch-enable pass-through in the board wrapper. It divides the board clock into the core clock, holds and releases the core reset in order, debounces the fetch-enable push-button, and gates core fetch-enable. A long button press while running re-sequences the core without reloading the FPGA.

## Interface
Parameters:
- DIV_HALF, 2: board clk cycles per core_clk_o half-period (2 → 50 MHz/4 = 12.5 MHz); ≥1.
- RST_HOLD, 16: core ticks core_rst_n_o is held low after entering HOLD; ≥1.
- FETCH_DELAY, 8: core ticks between core reset release and ARMED; ≥1.
- DEB_CYCLES, 65536: clk cycles the synchronized button must be stable to change debounced level; ≥2.
- LONG_TICKS, 4096: core ticks of continuous press in RUN that trigger re-sequence; ≥1.
- AUTO_FETCH, 0: 1 = go ARMED→RUN without button.

Ports:
- clk  in  1  board clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn_fetch_n  in  1  raw push-button, active low, asynchronous, bouncing.
- core_clk_o  out  1  divided core clock, flop-driven.
- core_rst_n_o  out  1  core reset, active low.
- fetch_enable_o  out  1  core fetch enable, active high.
- state_o  out  2  current state: HOLD=0, RELEASE=1, ARMED=2, RUN=3.

## Operation
- Divider: cnt 0..DIV_HALF-1 in clk; at cnt==DIV_HALF-1 core_clk_o toggles and cnt wraps to 0.
- Core tick: the clk cycle with cnt==DIV_HALF-1 and core_clk_o==1, i.e. the edge producing the core falling edge. All FSM transitions, tick counters, core_rst_n_o and fetch_enable_o updates occur only on core ticks. Core-domain signals therefore change mid-period and are stable at the next core rising edge.
- Debounce: 2-flop synchronizer, then a stable counter. If sync != deb, increment; at DEB_CYCLES-1, deb := sync and counter clears. If sync == deb, counter clears. press = ~deb. press_edge = deb 1→0, latched until consumed at the next core tick.
- FSM, one tick counter shared across states, cleared on every state entry:
  - HOLD: rst low, fetch 0. At count RST_HOLD-1 → RELEASE.
  - RELEASE: rst high, fetch 0. At count FETCH_DELAY-1 → ARMED.
  - ARMED: rst high, fetch 0. AUTO_FETCH=1 → RUN at the next tick. Otherwise a latched press_edge → RUN. A level held from earlier states does not count; a press_edge latch set before ARMED is discarded on entry.
  - RUN: rst high, fetch 1. The counter counts ticks with press=1 and clears when press=0. At LONG_TICKS-1 → HOLD. A short press has no effect.
- Entering HOLD from RUN drops core_rst_n_o and fetch_enable_o on the same tick.
- core_clk_o keeps running in all states.

## Timing
- Reset values: core_clk_o=0, core_rst_n_o=0, fetch_enable_o=0, state_o=0 (HOLD), all counters 0, deb=1, sync flops=1.
- rst_n assertion clears every output asynchronously, even mid-RUN. Deassertion re-runs HOLD; the core reset is released synchronously only.
- First core tick: clk cycle 2·DIV_HALF-1 after rst_n release. core_rst_n_o rises on tick RST_HOLD. state_o=ARMED on tick RST_HOLD+FETCH_DELAY.
- Button latency: 2 (sync) + DEB_CYCLES clk cycles to deb. RUN is entered at the next core tick, at most 2·DIV_HALF clk cycles later.
- Debounce counter width: $clog2(DEB_CYCLES). Tick counter width: $clog2(max(RST_HOLD, FETCH_DELAY, LONG_TICKS)). No wrap is possible; each count saturates into a transition.

## Structure
- Package boot_seq_pkg: state enum (HOLD, RELEASE, ARMED, RUN, 2-bit encoding as above) and the state_o encoding constants.
- Sub-module btn_debounce (parameter DEB_CYCLES; ports clk, rst_n, btn_n_i, deb_o, fall_o). It contains the synchronizer, stable counter and edge detect.
- Top level contains the divider, tick generation, press_edge latch and FSM.

## Test plan
All scenarios use DIV_HALF=2, RST_HOLD=4, FETCH_DELAY=3, DEB_CYCLES=8, LONG_TICKS=10, AUTO_FETCH=0 unless stated.
- Release rst_n, button idle → core_clk_o period 4 clk; core_rst_n_o rises at clk 4·4-1=15 after reset; state_o=2 at tick 7; fetch_enable_o stays 0 for 200 clk.
- In ARMED, btn low for 5 clk then high → no RUN. btn low 20 clk → deb falls 10 clk after the press; fetch_enable_o=1 and state_o=3 within 4 further clk.
- btn held low from reset through ARMED → stays ARMED. Release, then press for 20 clk → RUN.
- In RUN, hold btn 9 ticks → stays RUN. Release, then hold ≥10 ticks + debounce → core_rst_n_o=0, fetch_enable_o=0, state_o=0 on the same tick; reset re-sequences back to ARMED without a new press while btn stays low.
- Assert rst_n mid-RUN for 3 clk → core_rst_n_o, fetch_enable_o, core_clk_o go 0 immediately, without waiting for a clk edge; after release the full HOLD/RELEASE sequence repeats.
- AUTO_FETCH=1, DIV_HALF=1 → core_clk_o period 2 clk; state_o=3 and fetch_enable_o=1 at tick 8 with no button activity.
